// File: rtl/scd_shift_sequencer.sv
// Shift-count / exponent sequencer.
// Loads SC (shift mode) or FE (normalize mode), then issues one AR shift
// step per clock until the count runs out, AR normalizes, the step limit
// is reached or FE would underflow. A one-cycle done_h pulse closes out
// every operation that is not aborted or reset.
module scd_shift_sequencer #(
    parameter int SC_WIDTH  = 10,
    parameter int MAX_SHIFT = 72
) (
    input  logic                clk_scd_h,
    input  logic                mr_reset_h,
    input  logic                start_h,
    input  logic                mode_norm_h,
    input  logic                abort_h,
    input  logic [SC_WIDTH-1:0] sc_in_h,
    input  logic [SC_WIDTH-1:0] fe_in_h,
    input  logic                ar_00_h,
    input  logic                ar_01_h,
    input  logic                ar_zero_h,
    output logic                ready_h,
    output logic                busy_h,
    output logic                shift_left_h,
    output logic                shift_right_h,
    output logic                done_h,
    output logic                zero_h,
    output logic                fxu_h,
    output logic [SC_WIDTH-1:0] sc_h,
    output logic [SC_WIDTH-1:0] fe_h
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        NORM  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp bounds, normalize step limit and the most negative FE value.
    localparam logic signed [SC_WIDTH-1:0] MAX_POS    = SC_WIDTH'(MAX_SHIFT);
    localparam logic signed [SC_WIDTH-1:0] MAX_NEG    = -MAX_POS;
    localparam logic signed [SC_WIDTH-1:0] STEP_LIMIT = SC_WIDTH'(MAX_SHIFT - 1);
    localparam logic signed [SC_WIDTH-1:0] FE_MIN     = {1'b1, {(SC_WIDTH-1){1'b0}}};
    localparam logic signed [SC_WIDTH-1:0] ONE        = {{(SC_WIDTH-1){1'b0}}, 1'b1};

    state_t state, state_next;

    logic signed [SC_WIDTH-1:0] sc_q, sc_next;
    logic signed [SC_WIDTH-1:0] fe_q, fe_next;
    logic signed [SC_WIDTH-1:0] sc_in_s;
    logic signed [SC_WIDTH-1:0] sc_clamped;
    logic                       zero_q, zero_next;
    logic                       fxu_q, fxu_next;
    logic                       norm_step;

    assign sc_in_s = sc_in_h;

    // A normalize step is taken only when none of the terminating conditions hold.
    assign norm_step = ~ar_zero_h
                     & (ar_00_h == ar_01_h)
                     & (sc_q != STEP_LIMIT)
                     & (fe_q != FE_MIN);

    // Saturate the requested shift count to +/-MAX_SHIFT.
    always_comb begin
        sc_clamped = sc_in_s;
        if (sc_in_s > MAX_POS) begin
            sc_clamped = MAX_POS;
        end else if (sc_in_s < MAX_NEG) begin
            sc_clamped = MAX_NEG;
        end
    end

    // State, counter and flag registers; reset clears everything immediately.
    always_ff @(posedge clk_scd_h or posedge mr_reset_h) begin
        if (mr_reset_h) begin
            state  <= IDLE;
            sc_q   <= '0;
            fe_q   <= '0;
            zero_q <= 1'b0;
            fxu_q  <= 1'b0;
        end else begin
            state  <= state_next;
            sc_q   <= sc_next;
            fe_q   <= fe_next;
            zero_q <= zero_next;
            fxu_q  <= fxu_next;
        end
    end

    // Next-state and counter update; abort leaves SC/FE at their partial values.
    always_comb begin
        state_next = state;
        sc_next    = sc_q;
        fe_next    = fe_q;
        zero_next  = zero_q;
        fxu_next   = fxu_q;
        case (state)
            IDLE: begin
                if (start_h) begin
                    zero_next = 1'b0;
                    fxu_next  = 1'b0;
                    if (mode_norm_h) begin
                        fe_next    = fe_in_h;
                        sc_next    = '0;
                        state_next = NORM;
                    end else begin
                        sc_next    = sc_clamped;
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (abort_h) begin
                    state_next = IDLE;
                end else if (sc_q == '0) begin
                    state_next = DONE;
                end else if (!sc_q[SC_WIDTH-1]) begin
                    sc_next = sc_q - ONE;
                end else begin
                    sc_next = sc_q + ONE;
                end
            end
            NORM: begin
                if (abort_h) begin
                    state_next = IDLE;
                end else if (ar_zero_h) begin
                    zero_next  = 1'b1;
                    fe_next    = '0;
                    state_next = DONE;
                end else if (ar_00_h != ar_01_h) begin
                    state_next = DONE;
                end else if (sc_q == STEP_LIMIT) begin
                    zero_next  = 1'b1;
                    state_next = DONE;
                end else if (fe_q == FE_MIN) begin
                    fxu_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    fe_next = fe_q - ONE;
                    sc_next = sc_q + ONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status and shift strobes; an abort cycle never shifts.
    always_comb begin
        ready_h       = (state == IDLE);
        busy_h        = (state == SHIFT) || (state == NORM);
        done_h        = (state == DONE);
        shift_left_h  = 1'b0;
        shift_right_h = 1'b0;
        if (state == SHIFT && !abort_h) begin
            shift_left_h  = (sc_q != '0) && !sc_q[SC_WIDTH-1];
            shift_right_h = sc_q[SC_WIDTH-1];
        end else if (state == NORM && !abort_h) begin
            shift_left_h  = norm_step;
        end
    end

    assign zero_h = zero_q;
    assign fxu_h  = fxu_q;
    assign sc_h   = sc_q;
    assign fe_h   = fe_q;

endmodule

// File: tb/tb_scd_shift_sequencer.sv
// Directed bench for scd_shift_sequencer: a table of whole operations
// plus hand-written reset, abort and start-in-DONE sequences.
module tb_scd_shift_sequencer;

    logic       clk_scd_h = 1'b0;
    logic       mr_reset_h;
    logic       start_h, mode_norm_h, abort_h;
    logic [9:0] sc_in_h, fe_in_h;
    logic       ar_00_h, ar_01_h, ar_zero_h;
    logic       ready_h, busy_h, shift_left_h, shift_right_h, done_h, zero_h, fxu_h;
    logic [9:0] sc_h, fe_h;

    int numCompared   = 0;
    int numMismatched = 0;

    typedef struct {
        string      name;
        bit         mode;
        logic [9:0] scIn;
        logic [9:0] feIn;
        bit         arZero;
        int         normAfter;
        int         expLat;
        int         expLeft;
        int         expRight;
        logic [9:0] expSc;
        logic [9:0] expFe;
        bit         expZero;
        bit         expFxu;
    } vec_t;

    vec_t vecs[11];

    scd_shift_sequencer #(.SC_WIDTH(10), .MAX_SHIFT(72)) dut (
        .clk_scd_h    (clk_scd_h),
        .mr_reset_h   (mr_reset_h),
        .start_h      (start_h),
        .mode_norm_h  (mode_norm_h),
        .abort_h      (abort_h),
        .sc_in_h      (sc_in_h),
        .fe_in_h      (fe_in_h),
        .ar_00_h      (ar_00_h),
        .ar_01_h      (ar_01_h),
        .ar_zero_h    (ar_zero_h),
        .ready_h      (ready_h),
        .busy_h       (busy_h),
        .shift_left_h (shift_left_h),
        .shift_right_h(shift_right_h),
        .done_h       (done_h),
        .zero_h       (zero_h),
        .fxu_h        (fxu_h),
        .sc_h         (sc_h),
        .fe_h         (fe_h)
    );

    always #5 clk_scd_h = ~clk_scd_h;

    task automatic checkOutput(input string name, input int actual, input int expected);
        numCompared++;
        if (actual != expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_scd_h);
        #1;
    endtask

    // Runs one complete operation and checks strobe counts, latency and final state.
    task automatic applyStimulus(input vec_t v);
        int lefts;
        int rights;
        int lat;
        int both;
        lefts = 0; rights = 0; lat = -1; both = 0;
        start_h = 1'b1; mode_norm_h = v.mode; sc_in_h = v.scIn; fe_in_h = v.feIn;
        ar_zero_h = v.arZero; ar_00_h = 1'b0; ar_01_h = (v.normAfter == 0);
        #1;
        checkOutput({v.name, "/ready"}, int'(ready_h), 1);
        nextCycle();
        start_h = 1'b0; sc_in_h = ~v.scIn; fe_in_h = ~v.feIn;
        for (int c = 1; c <= 200; c++) begin
            ar_01_h = (lefts >= v.normAfter);
            #1;
            if (shift_left_h && shift_right_h) both = 1;
            lefts  += int'(shift_left_h);
            rights += int'(shift_right_h);
            if (done_h) begin
                lat = c;
                break;
            end
            nextCycle();
        end
        checkOutput({v.name, "/latency"}, lat, v.expLat);
        checkOutput({v.name, "/lefts"}, lefts, v.expLeft);
        checkOutput({v.name, "/rights"}, rights, v.expRight);
        checkOutput({v.name, "/both"}, both, 0);
        checkOutput({v.name, "/sc"}, int'(sc_h), int'(v.expSc));
        checkOutput({v.name, "/fe"}, int'(fe_h), int'(v.expFe));
        checkOutput({v.name, "/zero"}, int'(zero_h), int'(v.expZero));
        checkOutput({v.name, "/fxu"}, int'(fxu_h), int'(v.expFxu));
        nextCycle();
        checkOutput({v.name, "/idle_after"}, int'(ready_h), 1);
        checkOutput({v.name, "/done_once"}, int'(done_h), 0);
    endtask

    initial begin
        int sawDone;
        vec_t restart;

        vecs[0]  = '{"shift+3",     1'b0, 10'd3,   10'h155, 1'b0, 1000, 5,  3,  0,  10'd0,  10'd0,   1'b0, 1'b0};
        vecs[1]  = '{"shift-200",   1'b0, 10'h338, 10'h155, 1'b0, 1000, 74, 0,  72, 10'd0,  10'd0,   1'b0, 1'b0};
        vecs[2]  = '{"shift0",      1'b0, 10'd0,   10'h155, 1'b0, 1000, 2,  0,  0,  10'd0,  10'd0,   1'b0, 1'b0};
        vecs[3]  = '{"shift+100",   1'b0, 10'd100, 10'h155, 1'b0, 1000, 74, 72, 0,  10'd0,  10'd0,   1'b0, 1'b0};
        vecs[4]  = '{"shift-5",     1'b0, 10'h3FB, 10'h155, 1'b0, 1000, 7,  0,  5,  10'd0,  10'd0,   1'b0, 1'b0};
        vecs[5]  = '{"norm10",      1'b1, 10'h0AA, 10'd10,  1'b0, 4,    6,  4,  0,  10'd4,  10'd6,   1'b0, 1'b0};
        vecs[6]  = '{"norm_zero",   1'b1, 10'h0AA, 10'd10,  1'b1, 0,    2,  0,  0,  10'd0,  10'd0,   1'b1, 1'b0};
        vecs[7]  = '{"norm_fxu",    1'b1, 10'h0AA, 10'h201, 1'b0, 1000, 3,  1,  0,  10'd1,  10'h200, 1'b0, 1'b1};
        vecs[8]  = '{"shift+1",     1'b0, 10'd1,   10'h155, 1'b0, 1000, 3,  1,  0,  10'd0,  10'h200, 1'b0, 1'b0};
        vecs[9]  = '{"norm_limit",  1'b1, 10'h0AA, 10'd0,   1'b0, 1000, 73, 71, 0,  10'd71, 10'h3B9, 1'b1, 1'b0};
        vecs[10] = '{"norm_ready",  1'b1, 10'h0AA, 10'd0,   1'b0, 0,    2,  0,  0,  10'd0,  10'd0,   1'b0, 1'b0};

        mr_reset_h = 1'b1; start_h = 1'b0; mode_norm_h = 1'b0; abort_h = 1'b0;
        sc_in_h = '0; fe_in_h = '0; ar_00_h = 1'b0; ar_01_h = 1'b0; ar_zero_h = 1'b0;
        #1;
        checkOutput("rst/ready", int'(ready_h), 1);
        checkOutput("rst/busy", int'(busy_h), 0);
        checkOutput("rst/done", int'(done_h), 0);
        checkOutput("rst/sc", int'(sc_h), 0);
        checkOutput("rst/fe", int'(fe_h), 0);
        nextCycle();
        nextCycle();
        mr_reset_h = 1'b0;

        // Reset in the middle of a shift: outputs clear asynchronously, no done.
        start_h = 1'b1; mode_norm_h = 1'b0; sc_in_h = 10'd5;
        nextCycle();
        start_h = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("midrst/sc_before", int'(sc_h), 3);
        #2;
        mr_reset_h = 1'b1;
        #1;
        checkOutput("midrst/ready", int'(ready_h), 1);
        checkOutput("midrst/busy", int'(busy_h), 0);
        checkOutput("midrst/left", int'(shift_left_h), 0);
        checkOutput("midrst/sc", int'(sc_h), 0);
        nextCycle();
        mr_reset_h = 1'b0;
        sawDone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_h) sawDone = 1;
            nextCycle();
        end
        checkOutput("midrst/no_done", sawDone, 0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
        end

        // start_h held through a zero-count SHIFT and its DONE cycle is not accepted there.
        start_h = 1'b1; mode_norm_h = 1'b0; sc_in_h = 10'd0;
        nextCycle();
        sc_in_h = 10'd3;
        checkOutput("done_start/busy", int'(busy_h), 1);
        nextCycle();
        checkOutput("done_start/done", int'(done_h), 1);
        checkOutput("done_start/ready", int'(ready_h), 0);
        nextCycle();
        start_h = 1'b0;
        checkOutput("done_start/idle", int'(ready_h), 1);
        checkOutput("done_start/sc", int'(sc_h), 0);

        // abort together with start in IDLE: the start wins.
        nextCycle();
        start_h = 1'b1; abort_h = 1'b1; sc_in_h = 10'd2;
        nextCycle();
        start_h = 1'b0; abort_h = 1'b0;
        checkOutput("abort_idle/busy", int'(busy_h), 1);
        checkOutput("abort_idle/sc", int'(sc_h), 2);
        sawDone = 0;
        for (int i = 0; i < 10 && !sawDone; i++) begin
            if (done_h) sawDone = 1;
            else nextCycle();
        end
        checkOutput("abort_idle/done", sawDone, 1);
        nextCycle();

        // Abort a SHIFT of 10 after 4 steps.
        start_h = 1'b1; mode_norm_h = 1'b0; sc_in_h = 10'd10;
        nextCycle();
        start_h = 1'b0;
        for (int i = 0; i < 4; i++) nextCycle();
        abort_h = 1'b1;
        #1;
        checkOutput("abort_shift/left", int'(shift_left_h), 0);
        checkOutput("abort_shift/busy", int'(busy_h), 1);
        nextCycle();
        abort_h = 1'b0;
        checkOutput("abort_shift/ready", int'(ready_h), 1);
        checkOutput("abort_shift/sc", int'(sc_h), 6);
        checkOutput("abort_shift/done", int'(done_h), 0);

        restart = '{"restart+2", 1'b0, 10'd2, 10'h155, 1'b0, 1000, 4, 2, 0, 10'd0, 10'd0, 1'b0, 1'b0};
        applyStimulus(restart);

        // Abort a NORM after 2 steps: FE and SC keep their partial values.
        start_h = 1'b1; mode_norm_h = 1'b1; fe_in_h = 10'd10;
        ar_zero_h = 1'b0; ar_00_h = 1'b0; ar_01_h = 1'b0;
        nextCycle();
        start_h = 1'b0;
        nextCycle();
        nextCycle();
        abort_h = 1'b1;
        #1;
        checkOutput("abort_norm/left", int'(shift_left_h), 0);
        nextCycle();
        abort_h = 1'b0;
        checkOutput("abort_norm/ready", int'(ready_h), 1);
        checkOutput("abort_norm/fe", int'(fe_h), 8);
        checkOutput("abort_norm/sc", int'(sc_h), 2);
        checkOutput("abort_norm/done", int'(done_h), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
